// File: rtl/insn_line_cache_if.sv
// insn_line_cache_if
// Bundles the fetch port, the line refill port and the invalidation inputs
// of the instruction line cache.
//   core side : i_core_req, i_core_addr -> o_core_ack, o_core_data
//   mem side  : o_mem_req, o_mem_addr   -> i_mem_ack, i_mem_data
//   coherence : i_inv, i_inv_addr, i_flush_all
//   status    : o_busy (fetch stall)
// modport slave  : the cache itself
// modport master : the core / memory / coherence environment
interface insn_line_cache_if;
    logic         i_core_req;
    logic [31:0]  i_core_addr;
    logic         o_core_ack;
    logic [127:0] o_core_data;
    logic         o_mem_req;
    logic [31:0]  o_mem_addr;
    logic         i_mem_ack;
    logic [127:0] i_mem_data;
    logic         i_inv;
    logic [31:0]  i_inv_addr;
    logic         i_flush_all;
    logic         o_busy;

    modport slave (
        input  i_core_req, i_core_addr, i_mem_ack, i_mem_data,
               i_inv, i_inv_addr, i_flush_all,
        output o_core_ack, o_core_data, o_mem_req, o_mem_addr, o_busy
    );

    modport master (
        output i_core_req, i_core_addr, i_mem_ack, i_mem_data,
               i_inv, i_inv_addr, i_flush_all,
        input  o_core_ack, o_core_data, o_mem_req, o_mem_addr, o_busy
    );
endinterface

// File: rtl/insn_line_cache.sv
// insn_line_cache
// Direct-mapped instruction cache returning whole 128-bit lines to the core.
// A miss issues one line refill; single-line invalidation and full flush are
// accepted in any state.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : insn_line_cache_if.slave (core, memory, invalidation, busy)
// Parameter:
//   LINES : number of 16-byte lines (power of two, >= 2)
module insn_line_cache #(
    parameter int LINES = 16
) (
    input  logic              CLK,
    input  logic              RST,
    insn_line_cache_if.slave  bus
);
    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 28 - IDXW;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

    state_t             state_reg, state_next;
    logic [31:4]        addr_reg;
    logic               core_ack_reg;
    logic [127:0]       resp_reg;
    logic               mem_req_reg;
    logic [31:0]        mem_addr_reg;
    logic               busy_reg;

    logic [IDXW-1:0]    core_idx, addr_idx, inv_idx;
    logic [TAGW-1:0]    addr_tag, inv_tag;

    logic [127:0]       data_mem [LINES];
    logic [127:0]       data_rd_reg;
    logic [TAGW-1:0]    tag_reg  [LINES];
    logic [LINES-1:0]   valid_reg, valid_next;
    logic [LINES-1:0]   inv_kill;

    logic               fill_we;
    logic               lookup_hit;
    logic               unused_addr_bits;

    assign core_idx = bus.i_core_addr[4 +: IDXW];
    assign addr_idx = addr_reg[4 +: IDXW];
    assign addr_tag = addr_reg[31 -: TAGW];
    assign inv_idx  = bus.i_inv_addr[4 +: IDXW];
    assign inv_tag  = bus.i_inv_addr[31 -: TAGW];
    assign unused_addr_bits = ^{bus.i_core_addr[3:0], bus.i_inv_addr[3:0]};

    // Refill write; gated by reset so an abandoned refill never lands.
    assign fill_we = (state_reg == FILL) && bus.i_mem_ack && !RST;

    // Per-line tag and valid bookkeeping.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            logic fill_here;
            logic inv_tag_match;

            assign fill_here = fill_we && (addr_idx == IDXW'(gi));
            // When the line is being refilled this cycle, the invalidation is
            // judged against the incoming tag so it kills the new line.
            assign inv_tag_match = fill_here ? (addr_tag == inv_tag)
                                             : (tag_reg[gi] == inv_tag);
            assign inv_kill[gi]  = bus.i_inv && (inv_idx == IDXW'(gi)) && inv_tag_match;

            // Clears win over the refill set; flush wins over everything.
            assign valid_next[gi] = bus.i_flush_all ? 1'b0 :
                                    inv_kill[gi]    ? 1'b0 :
                                    fill_here       ? 1'b1 :
                                                      valid_reg[gi];

            always_ff @(posedge CLK) begin
                if (fill_here) begin
                    tag_reg[gi] <= addr_tag;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    // Line data RAM. The read is issued while IDLE from the incoming address
    // so the line is ready in LOOKUP; nothing writes between the two cycles.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_mem[addr_idx] <= bus.i_mem_data;
        end
        if (state_reg == IDLE) begin
            data_rd_reg <= data_mem[core_idx];
        end
    end

    // valid_next already folds in same-cycle invalidation, and no refill can
    // happen in LOOKUP, so it is the effective valid bit here.
    assign lookup_hit = valid_next[addr_idx] && (tag_reg[addr_idx] == addr_tag);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.i_core_req) state_next = LOOKUP;
            LOOKUP:  state_next = lookup_hit ? RESP : FILL;
            FILL:    if (bus.i_mem_ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            core_ack_reg <= 1'b0;
            resp_reg     <= '0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            busy_reg     <= (state_next != IDLE);
            core_ack_reg <= (state_next == RESP);

            if (state_reg == IDLE && bus.i_core_req) begin
                addr_reg <= bus.i_core_addr[31:4];
            end

            if (state_reg == LOOKUP) begin
                if (lookup_hit) begin
                    resp_reg <= data_rd_reg;
                end else begin
                    mem_req_reg  <= 1'b1;
                    mem_addr_reg <= {addr_reg, 4'h0};
                end
            end

            if (state_reg == FILL && bus.i_mem_ack) begin
                mem_req_reg <= 1'b0;
                resp_reg    <= bus.i_mem_data;
            end
        end
    end

    assign bus.o_core_ack  = core_ack_reg;
    assign bus.o_core_data = resp_reg;
    assign bus.o_mem_req   = mem_req_reg;
    assign bus.o_mem_addr  = mem_addr_reg;
    assign bus.o_busy      = busy_reg;
endmodule

// File: tb/tb_insn_line_cache.sv
module tb_insn_line_cache;
    logic clk;
    logic rst;
    int   vec_cnt;
    int   miss_cnt;

    insn_line_cache_if bus();

    insn_line_cache #(.LINES(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] D2 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] D3 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_5678;
    localparam logic [127:0] D4 = 128'h4444_4444_0000_0000_FFFF_FFFF_4444_4444;
    localparam logic [127:0] D5 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    localparam logic [127:0] D6 = 128'h6666_0123_6666_4567_6666_89AB_6666_CDEF;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ctl_now();
        return {125'd0, bus.o_busy, bus.o_mem_req, bus.o_core_ack};
    endfunction

    // One fetch of address a. For a miss, i_mem_ack (with exp_data) is driven
    // in cycle k. inv_cyc/flush_cyc pulse i_inv (at a) / i_flush_all in that
    // cycle; -1 disables. Cycle 0 is the cycle in which the request is sampled.
    task automatic fetch(input logic [31:0] a, input bit hit, input logic [127:0] exp_data,
                         input int k, input int inv_cyc, input int flush_cyc);
        int last;
        logic [2:0] exp_ctl;
        last = hit ? 2 : k + 1;
        for (int c = 0; c <= last + 1; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                bus.i_core_req  = 1'b1;
                bus.i_core_addr = a;
            end
            if (c == 1) bus.i_core_addr = 32'h1234_5670;
            if (c == last + 1) bus.i_core_req = 1'b0;
            bus.i_mem_ack   = (!hit && c == k);
            bus.i_mem_data  = (!hit && c == k) ? exp_data : 128'd0;
            bus.i_inv       = (c == inv_cyc);
            bus.i_inv_addr  = a;
            bus.i_flush_all = (c == flush_cyc);
            @(negedge clk);
            exp_ctl[2] = (c >= 1 && c <= last);
            exp_ctl[1] = (!hit && c >= 2 && c <= k);
            exp_ctl[0] = (c == last);
            check($sformatf("ctl %h c%0d", a, c), ctl_now(), {125'd0, exp_ctl});
            if (!hit && c == 2)
                check($sformatf("mem_addr %h", a), {96'd0, bus.o_mem_addr}, {96'd0, a[31:4], 4'h0});
            if (c == last)
                check($sformatf("data %h", a), bus.o_core_data, exp_data);
        end
        bus.i_mem_ack   = 1'b0;
        bus.i_inv       = 1'b0;
        bus.i_flush_all = 1'b0;
        $display("fetch %h %s data=%h", a, hit ? "hit " : "miss", bus.o_core_data);
    endtask

    task automatic pulse_inv(input logic [31:0] a, input bit flush);
        @(posedge clk); #1;
        bus.i_inv       = !flush;
        bus.i_inv_addr  = a;
        bus.i_flush_all = flush;
        @(posedge clk); #1;
        bus.i_inv       = 1'b0;
        bus.i_flush_all = 1'b0;
        $display("%s %h", flush ? "flush" : "inv  ", a);
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        rst              = 1'b1;
        bus.i_core_req   = 1'b0;
        bus.i_core_addr  = 32'd0;
        bus.i_mem_ack    = 1'b0;
        bus.i_mem_data   = 128'd0;
        bus.i_inv        = 1'b0;
        bus.i_inv_addr   = 32'd0;
        bus.i_flush_all  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ctl", ctl_now(), 128'd0);
        check("rst mem_addr", {96'd0, bus.o_mem_addr}, 128'd0);
        check("rst data", bus.o_core_data, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset done");

        // Cold miss, refill acked in cycle 5, then a hit on the same line.
        fetch(32'h8000_0010, 1'b0, D1, 5, -1, -1);
        fetch(32'h8000_001C, 1'b1, D1, 0, -1, -1);

        // Conflict on index 1: new tag evicts, old address misses again.
        fetch(32'h8000_0110, 1'b0, D2, 3, -1, -1);
        fetch(32'h8000_0110, 1'b1, D2, 0, -1, -1);
        fetch(32'h8000_0010, 1'b0, D1, 2, -1, -1);

        // Invalidation with a non-matching tag keeps the line.
        pulse_inv(32'h9000_0018, 1'b0);
        fetch(32'h8000_0010, 1'b1, D1, 0, -1, -1);
        // Matching tag drops it.
        pulse_inv(32'h8000_0018, 1'b0);
        fetch(32'h8000_0010, 1'b0, D3, 3, -1, -1);
        // Invalidation in the LOOKUP cycle turns a would-be hit into a miss.
        fetch(32'h8000_0010, 1'b0, D6, 2, 1, -1);

        // Flush coinciding with the refill ack: data still returned, line not kept.
        fetch(32'h8000_0020, 1'b0, D4, 4, -1, 4);
        fetch(32'h8000_0020, 1'b0, D5, 2, -1, -1);
        fetch(32'h8000_0020, 1'b1, D5, 0, -1, -1);
        // Invalidation targeting the line being refilled also leaves it invalid.
        fetch(32'h8000_0050, 1'b0, D2, 3, 3, -1);
        fetch(32'h8000_0050, 1'b0, D3, 2, -1, -1);
        // Earlier flush also removed index 1.
        fetch(32'h8000_0010, 1'b0, D1, 2, -1, -1);

        // Reset during FILL abandons the refill; a late ack is ignored.
        @(posedge clk); #1;
        bus.i_core_req  = 1'b1;
        bus.i_core_addr = 32'h8000_0030;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            rst            = (c == 3);
            if (c == 3) bus.i_core_req = 1'b0;
            bus.i_mem_ack  = (c == 6);
            bus.i_mem_data = (c == 6) ? D4 : 128'd0;
            @(negedge clk);
            if (c == 3) check("rstfill pre ctl", ctl_now(), 128'd6);
            if (c >= 4) check($sformatf("rstfill ctl c%0d", c), ctl_now(), 128'd0);
        end
        bus.i_mem_ack = 1'b0;
        $display("reset during fill, stray ack at cycle 6");
        fetch(32'h8000_0020, 1'b0, D6, 3, -1, -1);
        fetch(32'h8000_0010, 1'b0, D2, 2, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
